r2_butterfly_pipe: RTL and testbench



---
 rtl/r2_butterfly_pipe.sv | 182 ++++++++++++++++++
 tb/tb_r2_butterfly_pipe.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/r2_butterfly_pipe.sv
// r2_butterfly_pipe
//   Fully pipelined radix-2 DIT butterfly with twiddle multiply:
//     s1 = a + b*w,  s2 = a - b*w   on signed complex samples.
//   One butterfly per clock, no back-pressure, latency 4 register stages.
//
// Parameters
//   DW  data width of a, b, s1, s2 components (signed)
//   TW  twiddle width (signed Q1.(TW-1); -2^(TW-1) is exactly -1.0)
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid            input sample set valid
//   ar, ai, br, bi      operands a and b (DW bits each)
//   wr, wi              twiddle (TW bits each)
//   scale               1 = halve both outputs with round half-up
//   ovf_clr             clear the sticky overflow flag
//   out_valid           s1/s2 valid this cycle
//   s1r, s1i, s2r, s2i  butterfly outputs (hold between valid cycles)
//   ovf                 sticky: a valid output had a component out of DW range
//
// Build option
//   R2BF_SAT_EN  defined: out-of-range components saturate.
//                undefined: out-of-range components wrap to the low DW bits.
module r2_butterfly_pipe #(
    parameter int DW = 18,
    parameter int TW = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] ar,
    input  logic signed [DW-1:0] ai,
    input  logic signed [DW-1:0] br,
    input  logic signed [DW-1:0] bi,
    input  logic signed [TW-1:0] wr,
    input  logic signed [TW-1:0] wi,
    input  logic                 scale,
    input  logic                 ovf_clr,
    output logic                 out_valid,
    output logic signed [DW-1:0] s1r,
    output logic signed [DW-1:0] s1i,
    output logic signed [DW-1:0] s2r,
    output logic signed [DW-1:0] s2i,
    output logic                 ovf
);

    localparam int PW  = DW + TW;   // full product width
    localparam int PW1 = PW + 1;    // product sum/difference width
    localparam int TDW = DW + 2;    // rounded b*w width, never truncated
    localparam int SW  = DW + 3;    // a +/- t width

    // half-LSB of the Q1.(TW-1) product, for round half-up
    localparam logic signed [PW:0]   RND  = {{(PW-TW+2){1'b0}}, 1'b1, {(TW-2){1'b0}}};
    localparam logic signed [SW-1:0] MAXV = {{4{1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{4{1'b1}}, {(DW-1){1'b0}}};

    // vld_pipe[0..2]: stage 1..3 valids, vld_pipe[3]: output valid
    logic [3:0] vld_pipe;

    // ---------------- stage 1: input register ----------------
    logic signed [DW-1:0] a1r, a1i, b1r, b1i;
    logic signed [TW-1:0] w1r, w1i;
    logic                 sc1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            a1r <= '0; a1i <= '0; b1r <= '0; b1i <= '0;
            w1r <= '0; w1i <= '0; sc1 <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[2:0], in_valid};
            a1r <= ar; a1i <= ai; b1r <= br; b1i <= bi;
            w1r <= wr; w1i <= wi; sc1 <= scale;
        end
    end

    // ---------------- stage 2: full products ----------------
    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [DW-1:0] a2r, a2i;
    logic                 sc2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_rr <= '0; p_ii <= '0; p_ri <= '0; p_ir <= '0;
            a2r <= '0; a2i <= '0; sc2 <= 1'b0;
        end else begin
            p_rr <= PW'(b1r) * PW'(w1r);
            p_ii <= PW'(b1i) * PW'(w1i);
            p_ri <= PW'(b1r) * PW'(w1i);
            p_ir <= PW'(b1i) * PW'(w1r);
            a2r <= a1r; a2i <= a1i; sc2 <= sc1;
        end
    end

    // ---------------- stage 3: combine and round ----------------
    // (-1)*(-1) twice can reach 2^(PW-1), hence PW+1 bits before the shift
    // and DW+2 bits after it.
    logic signed [PW:0] tr_f, ti_f;
    logic               unused_rnd_bits;

    assign tr_f = PW1'(p_rr) - PW1'(p_ii) + RND;
    assign ti_f = PW1'(p_ri) + PW1'(p_ir) + RND;
    // the bits below the binary point are dropped by the shift
    assign unused_rnd_bits = ^{tr_f[TW-2:0], ti_f[TW-2:0]};

    logic signed [TDW-1:0] tr3, ti3;
    logic signed [DW-1:0]  a3r, a3i;
    logic                  sc3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tr3 <= '0; ti3 <= '0;
            a3r <= '0; a3i <= '0; sc3 <= 1'b0;
        end else begin
            // arithmetic shift by TW-1 == take bits [PW:TW-1]
            tr3 <= tr_f[PW:TW-1];
            ti3 <= ti_f[PW:TW-1];
            a3r <= a2r; a3i <= a2i; sc3 <= sc2;
        end
    end

    // ---------------- stage 4: sums, scale, reduce ----------------
    function automatic logic signed [SW-1:0] halve(input logic signed [SW-1:0] x,
                                                   input logic en);
        logic signed [SW-1:0] xp;
        xp = x + SW'(1);
        return en ? (xp >>> 1) : x;
    endfunction

    // returns {out_of_range, reduced value}
    function automatic logic [DW:0] reduce(input logic signed [SW-1:0] x);
        logic          oor;
        logic [DW-1:0] y;
        oor = (x > MAXV) || (x < MINV);
`ifdef R2BF_SAT_EN
        if (x > MAXV)      y = MAXV[DW-1:0];
        else if (x < MINV) y = MINV[DW-1:0];
        else               y = x[DW-1:0];
`else
        y = x[DW-1:0];
`endif
        return {oor, y};
    endfunction

    logic signed [SW-1:0] x1r, x1i, x2r, x2i;
    logic [DW:0]          r1r, r1i, r2r, r2i;
    logic                 any_oor;

    always_comb begin
        x1r = halve(SW'(a3r) + SW'(tr3), sc3);
        x1i = halve(SW'(a3i) + SW'(ti3), sc3);
        x2r = halve(SW'(a3r) - SW'(tr3), sc3);
        x2i = halve(SW'(a3i) - SW'(ti3), sc3);
        r1r = reduce(x1r);
        r1i = reduce(x1i);
        r2r = reduce(x2r);
        r2i = reduce(x2i);
        any_oor = r1r[DW] | r1i[DW] | r2r[DW] | r2i[DW];
    end

    // outputs load only on a valid sample and hold across bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1r <= '0; s1i <= '0; s2r <= '0; s2i <= '0;
        end else if (vld_pipe[2]) begin
            s1r <= r1r[DW-1:0];
            s1i <= r1i[DW-1:0];
            s2r <= r2r[DW-1:0];
            s2i <= r2i[DW-1:0];
        end
    end

    // sticky overflow: a new overflow wins over a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           ovf <= 1'b0;
        else if (vld_pipe[2] && any_oor)   ovf <= 1'b1;
        else if (ovf_clr)                  ovf <= 1'b0;
    end

    assign out_valid = vld_pipe[3];

endmodule

// File: tb/tb_r2_butterfly_pipe.sv
// tb_r2_butterfly_pipe
//   Self-checking bench for r2_butterfly_pipe (DW = TW = 18).
//   Stimulus pushes expected results into a queue; a negedge monitor pops
//   and compares whenever out_valid is high, checks hold during bubbles,
//   zero outputs during reset, latency, and the sticky ovf flag.
//   Honors R2BF_SAT_EN the same way the design does.
module tb_r2_butterfly_pipe;

    localparam int  DW  = 18;
    localparam int  TW  = 18;
    localparam longint DMAX = 131071;
    localparam longint DMIN = -131072;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic scale = 1'b0;
    logic ovf_clr = 1'b0;
    logic signed [DW-1:0] ar = '0, ai = '0, br = '0, bi = '0;
    logic signed [TW-1:0] wr = '0, wi = '0;
    logic                 out_valid, ovf;
    logic signed [DW-1:0] s1r, s1i, s2r, s2i;

    r2_butterfly_pipe #(.DW(DW), .TW(TW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .ar(ar), .ai(ai), .br(br), .bi(bi), .wr(wr), .wi(wi),
        .scale(scale), .ovf_clr(ovf_clr),
        .out_valid(out_valid), .s1r(s1r), .s1i(s1i), .s2r(s2r), .s2i(s2i),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct { longint ar, ai, br, bi, wr, wi; bit sc; } op_t;
    typedef struct { longint s1r, s1i, s2r, s2i; bit oor; int cyc; } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint fit(longint s);
`ifdef R2BF_SAT_EN
        if (s > DMAX) return DMAX;
        if (s < DMIN) return DMIN;
        return s;
`else
        longint m;
        m = ((s % 262144) + 262144) % 262144;
        return (m >= 131072) ? m - 262144 : m;
`endif
    endfunction

    function automatic exp_t model(op_t o);
        exp_t   e;
        longint t_r, t_i;
        longint s[4];
        t_r = (o.br * o.wr - o.bi * o.wi + 65536) >>> 17;   // floor((x + 0.5 LSB))
        t_i = (o.br * o.wi + o.bi * o.wr + 65536) >>> 17;
        s[0] = o.ar + t_r; s[1] = o.ai + t_i;
        s[2] = o.ar - t_r; s[3] = o.ai - t_i;
        e.oor = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (o.sc) s[k] = (s[k] + 1) >>> 1;
            if (s[k] > DMAX || s[k] < DMIN) e.oor = 1'b1;
        end
        e.s1r = fit(s[0]); e.s1i = fit(s[1]);
        e.s2r = fit(s[2]); e.s2i = fit(s[3]);
        e.cyc = 0;
        return e;
    endfunction

    function automatic op_t rnd_op();
        op_t o;
        o.ar = longint'($urandom_range(0, 262143)) - 131072;
        o.ai = longint'($urandom_range(0, 262143)) - 131072;
        o.br = longint'($urandom_range(0, 262143)) - 131072;
        o.bi = longint'($urandom_range(0, 262143)) - 131072;
        o.wr = longint'($urandom_range(0, 262143)) - 131072;
        o.wi = longint'($urandom_range(0, 262143)) - 131072;
        o.sc = 1'($urandom_range(0, 1));
        return o;
    endfunction

    // one clock of stimulus; dir=1 uses the hand-derived expectation de
    task automatic drive(input bit v, input op_t o, input bit clr,
                         input bit dir, input exp_t de);
        exp_t e;
        @(posedge clk); #1;
        in_valid = v;
        ovf_clr  = clr;
        ar = DW'(o.ar); ai = DW'(o.ai); br = DW'(o.br); bi = DW'(o.bi);
        wr = TW'(o.wr); wi = TW'(o.wi); scale = o.sc;
        if (v) begin
            e = dir ? de : model(o);
            e.cyc = cyc;
            sbq.push_back(e);
        end
    endtask

    exp_t ne = '{s1r: 0, s1i: 0, s2r: 0, s2i: 0, oor: 0, cyc: 0};

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, rnd_op(), 1'b0, 1'b0, ne);
    endtask

    // ---------------- monitor ----------------
    exp_t lastv = '{s1r: 0, s1i: 0, s2r: 0, s2i: 0, oor: 0, cyc: 0};
    bit   ovf_m = 1'b0;
    bit   clr_prev = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_ovf", ovf, 0);
            chk("rst_s1r", s1r, 0); chk("rst_s1i", s1i, 0);
            chk("rst_s2r", s2r, 0); chk("rst_s2i", s2i, 0);
            lastv = ne;
            ovf_m = 1'b0;
        end else begin
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_out_valid: out_valid=1 with no pending sample (cycle %0d)", cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("latency", cyc - e.cyc, 4);
                    chk("s1r", s1r, e.s1r); chk("s1i", s1i, e.s1i);
                    chk("s2r", s2r, e.s2r); chk("s2i", s2i, e.s2i);
                    ovf_m = e.oor ? 1'b1 : (clr_prev ? 1'b0 : ovf_m);
                    lastv = e;
                end
            end else begin
                chk("hold_s1r", s1r, lastv.s1r); chk("hold_s1i", s1i, lastv.s1i);
                chk("hold_s2r", s2r, lastv.s2r); chk("hold_s2i", s2i, lastv.s2i);
                if (clr_prev) ovf_m = 1'b0;
            end
            chk("ovf", ovf, ovf_m);
        end
        clr_prev = ovf_clr;
    end

    // ---------------- stimulus ----------------
    op_t  o_id  = '{ar: 1000, ai: 2000, br: 300, bi: -400, wr: 131071, wi: 0, sc: 0};
    exp_t e_id  = '{s1r: 1300, s1i: 1600, s2r: 700, s2i: 2400, oor: 0, cyc: 0};
    op_t  o_mj  = '{ar: 1000, ai: 2000, br: 300, bi: -400, wr: 0, wi: -131072, sc: 0};
    exp_t e_mj  = '{s1r: 600, s1i: 1700, s2r: 1400, s2i: 2300, oor: 0, cyc: 0};
    op_t  o_ov0 = '{ar: 131071, ai: 0, br: 131071, bi: 0, wr: 131071, wi: 0, sc: 0};
`ifdef R2BF_SAT_EN
    exp_t e_ov0 = '{s1r: 131071, s1i: 0, s2r: 1, s2i: 0, oor: 1, cyc: 0};
`else
    exp_t e_ov0 = '{s1r: -3, s1i: 0, s2r: 1, s2i: 0, oor: 1, cyc: 0};
`endif
    op_t  o_ov1 = '{ar: 131071, ai: 0, br: 131071, bi: 0, wr: 131071, wi: 0, sc: 1};
    exp_t e_ov1 = '{s1r: 131071, s1i: 0, s2r: 1, s2i: 0, oor: 0, cyc: 0};

    initial begin
        bit [15:0] pat;
        pat = 16'b1111_1111_0101_0011;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // identity and -j twiddles
        drive(1'b1, o_id, 1'b0, 1'b1, e_id);
        drive(1'b1, o_mj, 1'b0, 1'b1, e_mj);
        idle(6);

        // overflow, then clear, then the scaled version must not overflow
        drive(1'b1, o_ov0, 1'b0, 1'b1, e_ov0);
        idle(5);
        drive(1'b0, rnd_op(), 1'b1, 1'b0, ne);
        drive(1'b1, o_ov1, 1'b0, 1'b1, e_ov1);
        idle(6);

        // clear on the same edge as a new overflow: set wins, then clear alone
        drive(1'b1, o_ov0, 1'b0, 1'b1, e_ov0);
        idle(2);
        drive(1'b0, rnd_op(), 1'b1, 1'b0, ne);
        drive(1'b0, rnd_op(), 1'b1, 1'b0, ne);
        idle(6);

        // reset with three samples in flight
        for (int i = 0; i < 3; i++) drive(1'b1, rnd_op(), 1'b0, 1'b0, ne);
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b0;
        sbq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        idle(8);

        // fixed valid pattern with random data
        for (int i = 15; i >= 0; i--) drive(pat[i], rnd_op(), 1'b0, 1'b0, ne);
        idle(6);

        // random stream with random bubbles and clears
        for (int i = 0; i < 300; i++)
            drive($urandom_range(0, 3) != 0, rnd_op(), $urandom_range(0, 7) == 0, 1'b0, ne);
        idle(8);

        chk("scoreboard_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
